hard_drop_commit: RTL
=====================

# hard_drop_commit

Sequential commit stage directly downstream of the ghost landing-row calculator. On a hard-drop request it samples the active piece and its landing row (`ghost_y`), then writes the piece's occupied cells into a registered copy of the playfield, one mask cell per cycle. When finished it reports the drop distance and any top-out condition. Its `f_out` feeds the line-clear stage. The game FSM loads `f_out` back as the live field.

## Interface
Parameters:
- `CELLS`, 16: mask cells scanned per commit (4×4); fixed, not for override.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `hard_drop_req`  in  1  single-cycle request; sampled only in IDLE.
- `t_curr`  in  `tetromino_ctrl`  active piece (coordinate, rotation, 4×4 masks, cell code).
- `ghost_y`  in  signed [`FIELD_VERTICAL_WIDTH`:0]  landing row from ghost calculator.
- `f`  in  `field_t`  current settled field.
- `f_out`  out  `field_t`  committed field; valid when `done`=1.
- `busy`  out  1  high from LATCH through DONE inclusive.
- `done`  out  1  one-cycle pulse; commit complete.
- `drop_dist`  out  [`FIELD_VERTICAL_WIDTH`:0]  `ghost_y − t_curr.coordinate.y`, unsigned, saturate at 0 if negative.
- `top_out`  out  1  a set cell landed at row < 0; valid with `done`, held until the next LATCH.

## Operation
- States are IDLE → LATCH → WRITE → DONE → IDLE.
- **IDLE**
  - `busy`=0.
  - `hard_drop_req`=1 moves to LATCH.
- **LATCH** (1 cycle)
  - Registers `t_curr`, `ghost_y` and `f` into internal copies; the `f` copy becomes `f_out`.
  - Computes `drop_dist`.
  - Clears `top_out`.
  - Resets the scan index k to 0.
- **WRITE** (16 cycles, k = 0..15)
  - i = k[3:2], j = k[1:0].
  - A cell is *set* when the latched `data[rotation][i][j]` = 1.
  - For a set cell: tx = x + j, ty = `ghost_y` + i.
  - If ty < 0: set `top_out`, write nothing.
  - Else if 0 ≤ tx < `FIELD_HORIZONTAL` and ty < `FIELD_VERTICAL`: write the piece cell code into `f_out.data[ty][tx]`.
  - Else: ignore the cell (defensive only; the ghost row guarantees in-range cells).
  - Cells that are not set are never written.
  - Occupied targets are overwritten, with no collision check.
  - When k = 15, advance to DONE.
- **DONE** (1 cycle)
  - `done`=1, then return to IDLE.
- Requests arriving while `busy`=1 are dropped, not queued.
- Live `t_curr`, `ghost_y` and `f` may change freely after LATCH; only the latched copies are used.
- Arithmetic:
  - tx and ty are signed, with width `FIELD_VERTICAL_WIDTH`+2.
  - `drop_dist` is taken from a signed subtraction and then clamped.

## Timing
- Reset (async, any state) forces:
  - state=IDLE.
  - `f_out` = all cells `TETROMINO_EMPTY`.
  - `busy`=0, `done`=0, `drop_dist`=0, `top_out`=0, k=0.
- Reset asserted mid-commit abandons the commit; no partial field is kept.
- Request sampled at edge N gives LATCH in cycle N+1, WRITE in N+2..N+17, and DONE (`done`=1) in N+18.
- Next request is accepted at edge N+19 at the earliest.
- `f_out`, `drop_dist` and `top_out` stay stable from DONE until the next LATCH.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- `HARD_DROP_SCORE_EN`
  - **Defined:** adds output `drop_score` [`FIELD_VERTICAL_WIDTH`+1:0] = 2×`drop_dist`.
    - Registered in LATCH.
    - Reset value 0.
    - Holds until the next LATCH.
  - **Undefined:** the port and its register are absent; all other behaviour is identical.

## Structure
- Shared package (GLOBAL) carries:
  - the state enum `hd_state_t` {HD_IDLE, HD_LATCH, HD_WRITE, HD_DONE};
  - `HD_CELLS`=16.
- It reuses `tetromino_ctrl`, `field_t`, `FIELD_VERTICAL`, `FIELD_HORIZONTAL`, `FIELD_VERTICAL_WIDTH` and `TETROMINO_EMPTY`.
- No sub-module: the FSM, scan counter and field register live in one module.

## Test plan
- **Empty field, O piece.** Rotation 0, mask rows 1–2 cols 1–2, x=3, y=0, ghost_y=19; request at edge 0.
  - `done` at cycle 18.
  - Cells (20,4),(20,5),(21,4),(21,5) hold the O code; all others empty.
  - `drop_dist`=19, `top_out`=0.
- **Top-out.** I piece, horizontal in mask row 1, ghost_y=−2.
  - No cells written.
  - `top_out`=1, `drop_dist`=0 when coordinate.y=−2.
- **Request while busy.** Second request at cycle 5.
  - Ignored: `done` pulses once, at cycle 18.
  - A new request at cycle 19 completes at cycle 37.
- **Reset mid-WRITE.** `rst_n`=0 at cycle 10.
  - Immediately: `f_out` all empty, `busy`=0, `done` never pulses.
- **Input change after LATCH.** Alter `t_curr` and `f` during WRITE.
  - `f_out` reflects only the values latched at LATCH.
- **`HARD_DROP_SCORE_EN` defined.** `drop_dist`=12.
  - `drop_score`=24 from LATCH onward; reset gives 0.

Source files
------------

// File: rtl/hard_drop_commit_pkg.sv
// Shared playfield/piece types plus the hard-drop commit state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hard_drop_commit_pkg;

   localparam int FIELD_HORIZONTAL       = 10;
   localparam int FIELD_VERTICAL         = 22;
   localparam int FIELD_VERTICAL_WIDTH   = 5;
   localparam int FIELD_HORIZONTAL_WIDTH = 4;
   localparam int HD_CELLS               = 16;

   typedef logic [2:0] cell_t;

   localparam cell_t TETROMINO_EMPTY = 3'd0;
   localparam cell_t TETROMINO_I     = 3'd1;
   localparam cell_t TETROMINO_O     = 3'd2;
   localparam cell_t TETROMINO_T     = 3'd3;
   localparam cell_t TETROMINO_S     = 3'd4;
   localparam cell_t TETROMINO_Z     = 3'd5;
   localparam cell_t TETROMINO_J     = 3'd6;
   localparam cell_t TETROMINO_L     = 3'd7;

   typedef struct packed {
      logic signed [FIELD_VERTICAL_WIDTH:0] x;
      logic signed [FIELD_VERTICAL_WIDTH:0] y;
   } coord_t;

   // data[rotation][row][col]: one 4x4 occupancy mask per rotation
   typedef struct packed {
      coord_t                 coordinate;
      logic [1:0]             rotation;
      logic [3:0][3:0][3:0]   data;
      cell_t                  code;
   } tetromino_ctrl;

   typedef struct packed {
      cell_t [FIELD_VERTICAL-1:0][FIELD_HORIZONTAL-1:0] data;
   } field_t;

   typedef enum logic [1:0] {
      HD_IDLE,
      HD_LATCH,
      HD_WRITE,
      HD_DONE
   } hd_state_t;

   // Field with every cell empty; used for reset and as a clean baseline
   function automatic field_t empty_field();
      field_t r;
      for (int y = 0; y < FIELD_VERTICAL; y++) begin
         for (int x = 0; x < FIELD_HORIZONTAL; x++) begin
            r.data[y][x] = TETROMINO_EMPTY;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/hard_drop_commit.sv
// Hard-drop commit: latches piece/landing row/field, stamps piece cells into field copy.
// Latency: request at edge N -> LATCH N+1, WRITE N+2..N+17 (1 mask cell/cycle), done pulse N+18.
// Backpressure: none; requests while busy are dropped. HARD_DROP_SCORE_EN adds drop_score output.
module hard_drop_commit
   import hard_drop_commit_pkg::*;
(
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                hard_drop_req,
   input  tetromino_ctrl                       t_curr,
   input  logic signed [FIELD_VERTICAL_WIDTH:0] ghost_y,
   input  field_t                              f,
   output field_t                              f_out,
   output logic                                busy,
   output logic                                done,
   output logic [FIELD_VERTICAL_WIDTH:0]       drop_dist,
   output logic                                top_out
`ifdef HARD_DROP_SCORE_EN
   ,
   output logic [FIELD_VERTICAL_WIDTH+1:0]     drop_score
`endif
);

   localparam int W  = FIELD_VERTICAL_WIDTH;
   localparam int XW = FIELD_HORIZONTAL_WIDTH;
   localparam int TW = FIELD_VERTICAL_WIDTH + 2;

   localparam logic signed [TW-1:0] C_FH   = TW'(FIELD_HORIZONTAL);
   localparam logic signed [TW-1:0] C_FV   = TW'(FIELD_VERTICAL);
   localparam logic [3:0]           K_LAST = 4'(HD_CELLS - 1);

   hd_state_t            r_state;
   logic [3:0]           r_k;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_top_out;
   logic [W:0]           r_drop_dist;
   field_t               r_field;

   // Latched piece: only the parts the scan needs (y is consumed at accept time)
   logic signed [W:0]    r_x;
   logic [1:0]           r_rot;
   logic [3:0][3:0][3:0] r_mask;
   cell_t                r_code;
   logic signed [W:0]    r_ghost_y;

   logic                 w_accept;
   logic [1:0]           w_i;
   logic [1:0]           w_j;
   logic                 w_set;
   logic signed [TW-1:0] w_tx;
   logic signed [TW-1:0] w_ty;
   logic                 w_in_field;
   logic signed [TW-1:0] w_diff;
   logic [W:0]           w_dist;

   assign w_accept = (r_state == HD_IDLE) && hard_drop_req;

   // Scan index splits into mask row (i) and column (j)
   assign w_i   = r_k[3:2];
   assign w_j   = r_k[1:0];
   assign w_set = r_mask[r_rot][w_i][w_j];

   // Sign-extend to one extra bit so x+3 / ghost_y+3 can never wrap
   assign w_tx = {r_x[W], r_x} + {{W{1'b0}}, w_j};
   assign w_ty = {r_ghost_y[W], r_ghost_y} + {{W{1'b0}}, w_i};

   // Negative-row cells are handled separately as top-out; this only guards the array bounds
   assign w_in_field = !w_tx[TW-1] && (w_tx < C_FH) && !w_ty[TW-1] && (w_ty < C_FV);

   // Drop distance from live inputs at accept; a piece already below its ghost row reads as 0
   assign w_diff = {ghost_y[W], ghost_y} - {t_curr.coordinate.y[W], t_curr.coordinate.y};
   assign w_dist = w_diff[TW-1] ? '0 : w_diff[W:0];

   // Sequencer: IDLE -> LATCH -> WRITE x16 -> DONE -> IDLE, with busy/done flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= HD_IDLE;
         r_k     <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            HD_IDLE: begin
               if (hard_drop_req) begin
                  r_state <= HD_LATCH;
                  r_busy  <= 1'b1;
               end
            end
            HD_LATCH: begin
               r_state <= HD_WRITE;
               r_k     <= '0;
            end
            HD_WRITE: begin
               r_k <= r_k + 4'd1;
               if (r_k == K_LAST) begin
                  r_state <= HD_DONE;
                  r_done  <= 1'b1;
               end
            end
            HD_DONE: begin
               r_state <= HD_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= HD_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Capture piece, landing row and drop distance on the accepted request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x         <= '0;
         r_rot       <= '0;
         r_mask      <= '0;
         r_code      <= TETROMINO_EMPTY;
         r_ghost_y   <= '0;
         r_drop_dist <= '0;
      end else if (w_accept) begin
         r_x         <= t_curr.coordinate.x;
         r_rot       <= t_curr.rotation;
         r_mask      <= t_curr.data;
         r_code      <= t_curr.code;
         r_ghost_y   <= ghost_y;
         r_drop_dist <= w_dist;
      end
   end

   // Field copy: reload on accept, then stamp one set mask cell per WRITE cycle (overwrites freely)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_field   <= empty_field();
         r_top_out <= 1'b0;
      end else if (w_accept) begin
         r_field   <= f;
         r_top_out <= 1'b0;
      end else if ((r_state == HD_WRITE) && w_set) begin
         if (w_ty[TW-1]) begin
            r_top_out <= 1'b1;
         end else if (w_in_field) begin
            r_field.data[w_ty[W-1:0]][w_tx[XW-1:0]] <= r_code;
         end
      end
   end

`ifdef HARD_DROP_SCORE_EN
   logic [W+1:0] r_drop_score;

   // Score is twice the drop distance, captured alongside it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_drop_score <= '0;
      end else if (w_accept) begin
         r_drop_score <= {w_dist, 1'b0};
      end
   end

   assign drop_score = r_drop_score;
`endif

   assign f_out     = r_field;
   assign busy      = r_busy;
   assign done      = r_done;
   assign drop_dist = r_drop_dist;
   assign top_out   = r_top_out;

endmodule
